// File: rtl/mem_port_sram_slave_if.sv
// MemPort request/grant interface between a core port and its memory responder.
interface MemPort;
  logic        valid;
  logic [31:0] addr;
  logic        write_en;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport Master (output valid, addr, write_en, byte_en, wdata, input ready, rdata);
  modport Slave  (input valid, addr, write_en, byte_en, wdata, output ready, rdata);
endinterface

// File: rtl/mem_port_sram_slave.sv
// MemPort responder serving requests from a single-port synchronous SRAM with
// programmable wait states; read data is returned in the cycle after grant.
module mem_port_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  MemPort.Slave         mem,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          oor_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_resp_q, rd_resp_d;
  logic        oor_rd_q, oor_rd_d;
  logic        oor_q, oor_d;
  logic [31:0] hold_q, hold_d;

  logic [31:0] off;
  logic        in_range;
  logic        grant_raw;
  logic        grant;
  logic        access;
  logic        unused_off;

  assign off        = mem.addr - ADDR_BASE;
  assign in_range   = (mem.addr >= ADDR_BASE) && ({2'b00, off[31:2]} < DEPTH);
  assign unused_off = ^off[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_raw = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem.valid) begin
          if (WS == 4'd0) begin
            grant_raw = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!mem.valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS) begin
          grant_raw = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The zero-wait grant path is combinational from valid, so it is gated by
  // rst_n to keep ready and the SRAM strobes at their reset values during reset.
  assign grant     = grant_raw && rst_n;
  assign access    = grant && in_range;
  assign mem.ready = grant;

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (access) begin
      sram_cs    = 1'b1;
      sram_we    = mem.write_en;
      sram_be    = mem.byte_en;
      sram_addr  = off[AW+1:2];
      sram_wdata = mem.wdata;
    end
  end

  always_comb begin
    rd_resp_d = access && !mem.write_en;
    oor_rd_d  = grant && !in_range && !mem.write_en;
    oor_d     = grant && !in_range;
    hold_d    = hold_q;
    if (rd_resp_q) begin
      hold_d = sram_rdata;
    end else if (oor_rd_q) begin
      hold_d = '0;
    end
  end

  // The response cycle forwards SRAM data directly; hold_d already equals that.
  assign mem.rdata = hold_d;
  assign oor_err   = oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_resp_q <= 1'b0;
      oor_rd_q  <= 1'b0;
      oor_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_resp_q <= rd_resp_d;
      oor_rd_q  <= oor_rd_d;
      oor_q     <= oor_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: doc/mem_port_sram_slave.md
# mem_port_sram_slave

Responder end of the `MemPort` request/grant protocol. It sits on the memory side of the core's instruction or data port and serves requests from a single-port synchronous SRAM macro. It inserts a programmable number of wait states and returns read data in the cycle after grant, which is the cycle the core samples as `rvalid`. One instance is used per port (instruction, data).

## Interface
Parameters:
- `ADDR_BASE`, default `'h10000000`: byte address mapped to SRAM word 0.
- `DEPTH_WORDS`, default 4096: SRAM depth in 32-bit words. Must be a power of two, ≥2.
- `WAIT_STATES`, default 0: cycles between first `valid` and grant, range 0..15.
- `AW`, default `$clog2(DEPTH_WORDS)`: SRAM word-address width.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem`  MemPort.Slave  responder side of the request interface; fields below.
- `mem.valid`  in  1  request present.
- `mem.addr`  in  32  byte address.
- `mem.write_en`  in  1  1 = write, 0 = read.
- `mem.byte_en`  in  4  write byte lanes.
- `mem.wdata`  in  32  write data.
- `mem.ready`  out  1  grant, one-cycle pulse per accepted request.
- `mem.rdata`  out  32  read data, valid the cycle after grant, held until the next read response.
- `sram_cs`  out  1  SRAM chip select.
- `sram_we`  out  1  SRAM write strobe.
- `sram_be`  out  4  SRAM byte mask.
- `sram_addr`  out  AW  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, available 1 cycle after `sram_cs` with `sram_we`=0.
- `oor_err`  out  1  pulse in the response cycle of an out-of-range access.

## Operation
- Address decode: `off = mem.addr - ADDR_BASE`. The access is in range iff `mem.addr >= ADDR_BASE` and `off[31:2] < DEPTH_WORDS`. `sram_addr = off[AW+1:2]`. `addr[1:0]` is ignored.
- FSM has two states.
- **IDLE** state:
  - `valid`=1 and `WAIT_STATES`=0: grant in the same cycle (combinational `ready`); stay in IDLE.
  - `valid`=1 and `WAIT_STATES`>0: go to WAIT with `cnt`=1.
- **WAIT** state:
  - `valid`=0: abort and return to IDLE with `cnt`=0. No SRAM access, no grant.
  - `cnt`==`WAIT_STATES`: grant this cycle and return to IDLE.
  - Otherwise: `cnt`++.
- Grant cycle:
  - `mem.ready`=1.
  - In range: `sram_cs`=1, `sram_we`=`write_en`, `sram_be`=`byte_en`, `sram_wdata`=`wdata`.
  - Out of range: `sram_cs`=0 and the write is dropped.
  - Request fields are sampled only in the grant cycle.
- Response cycle (grant+1):
  - In-range read: `mem.rdata`=`sram_rdata`, and the value is captured into the hold register.
  - Out-of-range read: `mem.rdata`=0, hold register=0, `oor_err`=1.
  - Out-of-range write: `oor_err`=1, `rdata` unchanged.
  - In-range write: `rdata` unchanged.
- Outside response cycles, `mem.rdata` = hold register.
- All SRAM strobes are 0 except in an in-range grant cycle.

## Timing
- Reset values: `mem.ready`=0, `mem.rdata`=0, `sram_cs`=0, `sram_we`=0, `sram_be`=0, `sram_addr`=0, `sram_wdata`=0, `oor_err`=0, state=IDLE, `cnt`=0, hold=0.
- Grant latency from first `valid` cycle: `WAIT_STATES` cycles (0 means same cycle). Read data arrives `WAIT_STATES`+1 cycles after first `valid`.
- Throughput:
  - `WAIT_STATES`=0: one grant per cycle. Back-to-back reads return data on consecutive cycles.
  - `WAIT_STATES`=N>0: one grant per N+1 cycles, because the cycle after a grant re-enters counting.
- A write granted in the cycle after a read grant does not disturb that read's response data.
- Reset asserted mid-wait or in a response cycle: outputs go to reset values immediately (asynchronously). A pending grant or response is lost. Operation resumes on the first edge after deassertion.
- `rst_n` deassertion is synchronized externally. This block assumes release is clean to `clk`.

## Test plan
- `WAIT_STATES`=0:
  - Stimulus: write `0xA5A5A5A5` with `be`=`4'hF` to `0x10000010`, then read `0x10000010`.
  - Required: `ready` is high in both request cycles, `sram_addr`=4, and `rdata`=`0xA5A5A5A5` in the cycle after the read grant.
- Byte enables:
  - Stimulus: write `0xFFFFFFFF`, then write `0x00000000` with `be`=`4'b0101`, then read.
  - Required: `rdata`=`0xFF00FF00`.
- `WAIT_STATES`=3:
  - Stimulus: hold `valid` continuously for 8 reads to consecutive words.
  - Required: `ready` pulses every 4th cycle, each `rdata` matches its preloaded word, and `rdata` is held stable between responses.
- Out of range:
  - Stimulus: read `0x0FFFFFFC`; read `ADDR_BASE+4*DEPTH_WORDS`; write to an out-of-range address.
  - Required: each is granted with `sram_cs`=0, `oor_err`=1 in the response cycle, reads return `rdata`=0, and SRAM contents are unchanged.
- Abort:
  - Stimulus: `WAIT_STATES`=3, `valid` high for 2 cycles then low.
  - Required: no `ready`, no `sram_cs`. A new request afterward is granted exactly 3 cycles after its first `valid`.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 in the response cycle of a read of `0x12345678`.
  - Required: `rdata` drops to 0 without a clock edge. After release, a fresh read of the same address returns `0x12345678`.
